// File: rtl/regfile_wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter_if
// Writeback request bundle for the two sources that share the register-file
// write port.
//   Port A (in-order pipeline): a_valid_i, a_addr_i, a_data_i -> a_ready_o
//   Port B (long-latency unit): b_valid_i, b_addr_i, b_data_i -> b_ready_o
// Modports:
//   slave  - the arbiter side (takes requests, returns ready)
//   master - the requester side (drives requests, observes ready)
// -----------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              a_valid_i;
  logic              a_ready_o;
  logic [ADDR_W-1:0] a_addr_i;
  logic [DATA_W-1:0] a_data_i;

  logic              b_valid_i;
  logic              b_ready_o;
  logic [ADDR_W-1:0] b_addr_i;
  logic [DATA_W-1:0] b_data_i;

  modport slave (
    input  a_valid_i, a_addr_i, a_data_i,
    input  b_valid_i, b_addr_i, b_data_i,
    output a_ready_o, b_ready_o
  );

  modport master (
    output a_valid_i, a_addr_i, a_data_i,
    output b_valid_i, b_addr_i, b_data_i,
    input  a_ready_o, b_ready_o
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
// Arbitrates the single register-file write port between a priority source
// (port A) and a starvation-protected long-latency source (port B), keeps a
// pending-write scoreboard for port-B destinations, and registers the winning
// write for one cycle before it reaches the regfile.
//
// Ports:
//   clk_i, rst_i            clock (rising edge), asynchronous active-high reset
//   wb (slave modport)      port A / port B valid-ready write requests
//   rsv_i, rsv_addr_i       reserve a register for a future port-B write
//   rs1/rs2_addr_i          decode source addresses
//   rs1/rs2_busy_o          source has a pending port-B write
//   rd_wren_o/addr_o/data_o registered regfile write port
//
// Optional feature (macro REGFILE_WB_FWD_EN): adds rs1/rs2_fwd_valid_o and
// rs1/rs2_fwd_data_o, exposing the write that is in flight on the output
// stage so decode can bypass instead of stalling one more cycle.
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  regfile_wb_arbiter_if.slave wb,
  input  logic               rsv_i,
  input  logic [ADDR_W-1:0]  rsv_addr_i,
  input  logic [ADDR_W-1:0]  rs1_addr_i,
  input  logic [ADDR_W-1:0]  rs2_addr_i,
  output logic               rs1_busy_o,
  output logic               rs2_busy_o,
`ifdef REGFILE_WB_FWD_EN
  output logic               rs1_fwd_valid_o,
  output logic [DATA_W-1:0]  rs1_fwd_data_o,
  output logic               rs2_fwd_valid_o,
  output logic [DATA_W-1:0]  rs2_fwd_data_o,
`endif
  output logic               rd_wren_o,
  output logic [ADDR_W-1:0]  rd_addr_o,
  output logic [DATA_W-1:0]  rd_data_o
);

  localparam int NREG = 2 ** ADDR_W;

  typedef enum logic {A_PRIO, B_FORCED} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  wait_cnt_reg, wait_cnt_next;
  logic        a_ready, b_ready;
  logic        a_hs, b_hs;

  logic [NREG-1:0] mask_reg;
  logic [NREG-1:0] set_vec, clr_vec;

  // ---------------------------------------------------------------------------
  // Arbitration FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg    <= A_PRIO;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    a_ready       = 1'b1;
    b_ready       = 1'b1;
    case (state_reg)
      A_PRIO: begin
        b_ready = !wb.a_valid_i;
        if (!wb.b_valid_i || b_ready) begin
          wait_cnt_next = '0;
        end else begin
          // B was refused this cycle; the edge that brings the count to
          // MAX_WAIT also flips the grant so the next cycle belongs to B.
          wait_cnt_next = wait_cnt_reg + 4'd1;
          if (wait_cnt_next == 4'(MAX_WAIT)) begin
            state_next = B_FORCED;
          end
        end
      end
      B_FORCED: begin
        a_ready = 1'b0;
        // B is always ready here, so either it handshakes or it has
        // withdrawn; both return control to A.
        state_next    = A_PRIO;
        wait_cnt_next = '0;
      end
      default: begin
        state_next    = A_PRIO;
        wait_cnt_next = '0;
      end
    endcase
  end

  assign wb.a_ready_o = a_ready;
  assign wb.b_ready_o = b_ready;

  // Grants are mutually exclusive: A_PRIO gates B on A, B_FORCED blocks A.
  assign a_hs = wb.a_valid_i && a_ready;
  assign b_hs = wb.b_valid_i && b_ready;

  // ---------------------------------------------------------------------------
  // Registered write stage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_wren_o <= 1'b0;
      rd_addr_o <= '0;
      rd_data_o <= '0;
    end else if (a_hs) begin
      rd_wren_o <= (wb.a_addr_i != '0);
      rd_addr_o <= wb.a_addr_i;
      rd_data_o <= wb.a_data_i;
    end else if (b_hs) begin
      rd_wren_o <= (wb.b_addr_i != '0);
      rd_addr_o <= wb.b_addr_i;
      rd_data_o <= wb.b_data_i;
    end else begin
      rd_wren_o <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending-write scoreboard (bit 0 never set: x0 is never pending)
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_mask
      if (gi == 0) begin : g_zero
        assign set_vec[gi] = 1'b0;
        assign clr_vec[gi] = 1'b0;
      end else begin : g_bit
        assign set_vec[gi] = rsv_i && (rsv_addr_i == ADDR_W'(gi));
        assign clr_vec[gi] = b_hs && (wb.b_addr_i == ADDR_W'(gi));
      end
    end
  endgenerate

  // Set is applied after clear so a same-cycle reserve wins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mask_reg <= '0;
    end else begin
      mask_reg <= (mask_reg & ~clr_vec) | set_vec;
    end
  end

  assign rs1_busy_o = mask_reg[rs1_addr_i];
  assign rs2_busy_o = mask_reg[rs2_addr_i];

`ifdef REGFILE_WB_FWD_EN
  assign rs1_fwd_valid_o = rd_wren_o && (rd_addr_o == rs1_addr_i) && (rs1_addr_i != '0);
  assign rs2_fwd_valid_o = rd_wren_o && (rd_addr_o == rs2_addr_i) && (rs2_addr_i != '0);
  assign rs1_fwd_data_o  = rd_data_o;
  assign rs2_fwd_data_o  = rd_data_o;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Directed scenarios followed by randomized traffic, all checked every cycle
// against a behavioural model: a refused-run counter for B, a bit array for
// pending registers and the expected registered write.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int MW = 4;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  regfile_wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) wb_if ();

  logic          rsv_i;
  logic [AW-1:0] rsv_addr_i, rs1_addr_i, rs2_addr_i;
  logic          rs1_busy_o, rs2_busy_o;
  logic          rd_wren_o;
  logic [AW-1:0] rd_addr_o;
  logic [DW-1:0] rd_data_o;
`ifdef REGFILE_WB_FWD_EN
  logic          rs1_fwd_valid_o, rs2_fwd_valid_o;
  logic [DW-1:0] rs1_fwd_data_o, rs2_fwd_data_o;
`endif

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(MW)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wb         (wb_if),
    .rsv_i      (rsv_i),
    .rsv_addr_i (rsv_addr_i),
    .rs1_addr_i (rs1_addr_i),
    .rs2_addr_i (rs2_addr_i),
    .rs1_busy_o (rs1_busy_o),
    .rs2_busy_o (rs2_busy_o),
`ifdef REGFILE_WB_FWD_EN
    .rs1_fwd_valid_o (rs1_fwd_valid_o),
    .rs1_fwd_data_o  (rs1_fwd_data_o),
    .rs2_fwd_valid_o (rs2_fwd_valid_o),
    .rs2_fwd_data_o  (rs2_fwd_data_o),
`endif
    .rd_wren_o  (rd_wren_o),
    .rd_addr_o  (rd_addr_o),
    .rd_data_o  (rd_data_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int            run_m;      // consecutive cycles B has been refused
  bit [31:0]     mask_m;     // pending port-B destinations
  bit            exp_wren;
  bit [AW-1:0]   exp_addr;
  bit [DW-1:0]   exp_data;

  task automatic model_reset();
    run_m    = 0;
    mask_m   = '0;
    exp_wren = 1'b0;
    exp_addr = '0;
    exp_data = '0;
  endtask

  task automatic drive(input bit av, input bit [AW-1:0] aa, input bit [DW-1:0] ad,
                       input bit bv, input bit [AW-1:0] ba, input bit [DW-1:0] bd,
                       input bit rsv, input bit [AW-1:0] ra,
                       input bit [AW-1:0] r1, input bit [AW-1:0] r2);
    wb_if.a_valid_i = av; wb_if.a_addr_i = aa; wb_if.a_data_i = ad;
    wb_if.b_valid_i = bv; wb_if.b_addr_i = ba; wb_if.b_data_i = bd;
    rsv_i = rsv; rsv_addr_i = ra; rs1_addr_i = r1; rs2_addr_i = r2;
  endtask

  // One clock cycle: check the registered write from the last edge, apply
  // inputs, check the combinational outputs, then advance the model.
  task automatic cycle(input bit av, input bit [AW-1:0] aa, input bit [DW-1:0] ad,
                       input bit bv, input bit [AW-1:0] ba, input bit [DW-1:0] bd,
                       input bit rsv, input bit [AW-1:0] ra,
                       input bit [AW-1:0] r1, input bit [AW-1:0] r2);
    bit ar, br, ahs, bhs;
    @(negedge clk_i);
    check("rd_wren", DW'(rd_wren_o), DW'(exp_wren));
    check("rd_addr", DW'(rd_addr_o), DW'(exp_addr));
    check("rd_data", rd_data_o, exp_data);
    drive(av, aa, ad, bv, ba, bd, rsv, ra, r1, r2);
    #1;
    ar = (run_m < MW);
    br = (run_m >= MW) || !av;
    check("a_ready", DW'(wb_if.a_ready_o), DW'(ar));
    check("b_ready", DW'(wb_if.b_ready_o), DW'(br));
    check("rs1_busy", DW'(rs1_busy_o), DW'(mask_m[r1]));
    check("rs2_busy", DW'(rs2_busy_o), DW'(mask_m[r2]));
`ifdef REGFILE_WB_FWD_EN
    check("rs1_fwd_valid", DW'(rs1_fwd_valid_o), DW'(exp_wren && exp_addr == r1 && r1 != 0));
    check("rs2_fwd_valid", DW'(rs2_fwd_valid_o), DW'(exp_wren && exp_addr == r2 && r2 != 0));
    if (exp_wren && exp_addr == r1 && r1 != 0) check("rs1_fwd_data", rs1_fwd_data_o, exp_data);
    if (exp_wren && exp_addr == r2 && r2 != 0) check("rs2_fwd_data", rs2_fwd_data_o, exp_data);
`endif
    ahs = av && ar;
    bhs = bv && br && !ahs;
    if (ahs) begin
      exp_wren = (aa != 0); exp_addr = aa; exp_data = ad;
    end else if (bhs) begin
      exp_wren = (ba != 0); exp_addr = ba; exp_data = bd;
    end else begin
      exp_wren = 1'b0;
    end
    if (bhs) mask_m[ba] = 1'b0;
    if (rsv && ra != 0) mask_m[ra] = 1'b1;
    if (bv && !br) run_m++;
    else run_m = 0;
  endtask

  task automatic idle(input bit [AW-1:0] r1, input bit [AW-1:0] r2);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, r1, r2);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset(input bit [AW-1:0] r1);
    @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, r1, r1);
    #1;
    check("rst_wren", DW'(rd_wren_o), '0);
    check("rst_addr", DW'(rd_addr_o), '0);
    check("rst_data", rd_data_o, '0);
    check("rst_busy", DW'(rs1_busy_o), '0);
    check("rst_a_ready", DW'(wb_if.a_ready_o), DW'(1));
    check("rst_b_ready", DW'(wb_if.b_ready_o), DW'(1));
    @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset(0);

    // A writes x5, then idle: one write pulse
    cycle(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 0);
    idle(5, 0);
    idle(5, 0);

    // A continuous with B waiting: B refused MW cycles then forced
    for (int i = 0; i < MW + 3; i++)
      cycle(1, AW'(i + 1), DW'(32'h100 + i), 1, 12, 32'hB0B0B0B0, 0, 0, 12, 0);
    idle(0, 0);

    // A writes x0: accepted, never a write pulse
    cycle(1, 0, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 0);
    idle(0, 0);

    // Reserve x7 (and attempt x0), then B writes x7
    cycle(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 0, 7, 0);
    idle(7, 0);
    cycle(0, 0, 0, 1, 7, 32'h55, 0, 0, 7, 0);
    idle(7, 0);
    idle(7, 0);

    // Reserve and B-write x9 in the same cycle: stays pending
    cycle(0, 0, 0, 0, 0, 0, 1, 9, 0, 9);
    cycle(0, 0, 0, 1, 9, 32'h99, 1, 9, 0, 9);
    idle(0, 9);
    cycle(0, 0, 0, 1, 9, 32'h9A, 0, 0, 0, 9);
    idle(0, 9);

    // Forward the in-flight write of x3
    cycle(1, 3, 32'hA5, 0, 0, 0, 0, 0, 3, 3);
    idle(3, 3);

    // Reset in B_FORCED with x7 pending
    cycle(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    for (int i = 0; i < MW; i++)
      cycle(1, 2, 32'h22, 1, 8, 32'h88, 0, 0, 7, 0);
    do_reset(7);
    idle(7, 0);
    idle(7, 0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset(AW'($urandom_range(0, 7)));
      end else begin
        cycle($urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)), DW'($urandom),
              $urandom_range(0, 2) != 0, AW'($urandom_range(0, 7)), DW'($urandom),
              $urandom_range(0, 3) == 0, AW'($urandom_range(0, 7)),
              AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
      end
    end
    idle(0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback sources.
  - Port A: in-order pipeline writeback. Has priority.
  - Port B: long-latency unit (LSU/mul/div). Starvation-protected.
- Keeps a pending-write scoreboard for port-B destinations so decode can stall on RAW hazards.
- Drives the regfile write port (rd_addr/rd_data/rd_wren) through one registered stage.

Parameters:
- DATA_W, 32, write data width.
- ADDR_W, 5, register address width (2**ADDR_W registers).
- MAX_WAIT, 4, consecutive cycles B may be refused while valid before it is forced; legal range 1..15.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- a_valid_i  in  1  port A write request.
- a_ready_o  out  1  port A accepted this cycle.
- a_addr_i  in  ADDR_W  port A destination register.
- a_data_i  in  DATA_W  port A write data.
- b_valid_i  in  1  port B write request.
- b_ready_o  out  1  port B accepted this cycle.
- b_addr_i  in  ADDR_W  port B destination register.
- b_data_i  in  DATA_W  port B write data.
- rsv_i  in  1  reserve a register for a future port-B write.
- rsv_addr_i  in  ADDR_W  register to reserve.
- rs1_addr_i  in  ADDR_W  decode source 1 address.
- rs2_addr_i  in  ADDR_W  decode source 2 address.
- rs1_busy_o  out  1  rs1 has a pending port-B write.
- rs2_busy_o  out  1  rs2 has a pending port-B write.
- rd_wren_o  out  1  regfile write enable.
- rd_addr_o  out  ADDR_W  regfile write address.
- rd_data_o  out  DATA_W  regfile write data.

Behaviour:
- Reset (rst_i=1, async):
  - rd_wren_o=0, rd_addr_o=0, rd_data_o=0.
  - wait_cnt=0, state=A_PRIO, pending mask=0.
  - a_ready_o=1, b_ready_o=1 (combinational from state and valids).
- Reset mid-operation: in-flight output stage and all reservations are discarded. No write issues on the first edge after release.
- States:
  - A_PRIO:
    - a_ready_o=1; b_ready_o = !a_valid_i.
    - wait_cnt increments on each cycle with b_valid_i && !b_ready_o.
    - wait_cnt clears on a B handshake or when b_valid_i=0.
    - When wait_cnt reaches MAX_WAIT -> B_FORCED (registered).
  - B_FORCED:
    - a_ready_o=0, b_ready_o=1.
    - On B handshake -> A_PRIO, wait_cnt=0.
    - If b_valid_i drops before handshake -> A_PRIO, wait_cnt=0.
- Handshake = valid && ready. At most one handshake per cycle.
- Output stage, 1-cycle latency:
  - On the edge after a handshake: rd_addr_o/rd_data_o = winner's addr/data; rd_wren_o = (addr != 0).
  - With no handshake: rd_wren_o=0; addr and data hold their last values.
- Writes to x0 complete the handshake, never assert rd_wren_o, and clear nothing.
- Scoreboard (pending mask, 2**ADDR_W bits, bit 0 hardwired 0):
  - rsv_i with rsv_addr_i != 0 sets the bit at the edge.
  - A port-B handshake clears bit b_addr_i at the same edge.
  - Set and clear of the same address in one cycle: set wins.
  - Reserving an already-set bit leaves it set; there is no counting.
  - Port-A writes never touch the mask.
- Busy lookup: rsX_busy_o = mask[rsX_addr_i], combinational. Always 0 for address 0.
- Busy clears the cycle after B's handshake, when rd_wren_o=1 for that register. The regfile updates on the following edge, so decode must use forwarding or stall one more cycle; see the optional feature.

Optional Feature:
- Macro: REGFILE_WB_FWD_EN.
- When defined, adds four outputs:
  - rs1_fwd_valid_o (1), rs1_fwd_data_o (DATA_W)
  - rs2_fwd_valid_o (1), rs2_fwd_data_o (DATA_W)
- rsX_fwd_valid_o = rd_wren_o && (rd_addr_o == rsX_addr_i) && (rsX_addr_i != 0).
- rsX_fwd_data_o = rd_data_o. This covers the write-in-flight cycle.
- When not defined: the ports are absent and the logic is removed. Decode must stall one extra cycle after busy drops.

Test Plan:
- Reset, then A writes x5=0xDEADBEEF -> next cycle rd_wren_o=1, rd_addr_o=5, rd_data_o=0xDEADBEEF; following cycle rd_wren_o=0.
- A and B both valid, A continuous, MAX_WAIT=4 -> B refused 4 cycles; 5th cycle a_ready_o=0, b_ready_o=1; B's data appears on the output the next cycle.
- A writes x0=0x1234 -> a_ready_o=1, rd_wren_o stays 0 throughout.
- rsv_i with addr 7, later B writes x7=0x55 -> rs1_busy_o=1 (rs1_addr_i=7) from the cycle after rsv until the cycle after the B handshake; never set for rsv_addr_i=0.
- Same cycle: rsv_i addr 9 and B handshake to x9 -> bit 9 stays set; rs2_busy_o=1.
- Assert rst_i mid-cycle with B_FORCED and mask=0x80 -> outputs 0 immediately; mask=0, a_ready_o=1 after release. With REGFILE_WB_FWD_EN: write x3=0xA5 -> rs1_fwd_valid_o=1, rs1_fwd_data_o=0xA5 when rs1_addr_i=3 in the output cycle.
